// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready front end for a two-port synchronous SRAM with a 3-entry response buffer.
// Latency: read response valid two cycles after the read fires (buffer empty); writes land at the fire edge.
// Backpressure: writes never stall; rd_ready drops once buffered + in-flight responses reach 3.
// Build option: define SRAM_CTRL_FWD_EN for same-cycle read-after-write forwarding.
module sram_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_valid,
  output logic                  o_rd_ready,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_sram_ce,
  output logic                  o_sram_we,
  output logic [ADDR_WIDTH-1:0] o_sram_waddr,
  output logic [DATA_WIDTH-1:0] o_sram_wdata,
  output logic                  o_sram_re,
  output logic [ADDR_WIDTH-1:0] o_sram_raddr,
  input  logic [DATA_WIDTH-1:0] i_sram_rdata
);

  // The SRAM cannot hold more entries than its address space reaches.
  if (DATA_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sram_ctrl: DATA_DEPTH exceeds 2**ADDR_WIDTH");
  end

  // Response buffer state: 3 entries, pointers wrap modulo 3.
  logic [DATA_WIDTH-1:0] r_mem [3];
  logic [1:0]            r_wptr;
  logic [1:0]            r_rptr;
  logic [1:0]            r_cnt;
  // One read in flight inside the SRAM; its data is valid on i_sram_rdata now.
  logic                  r_pend;

  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic [DATA_WIDTH-1:0] w_push_dat;

  // Occupancy counts the in-flight read so a full buffer can never be overrun.
  assign w_occ      = {1'b0, r_cnt} + {2'b00, r_pend};
  assign o_wr_ready = ~i_rst;
  assign o_rd_ready = ~i_rst & (w_occ < 3'd3);

  assign w_wr_fire  = i_wr_valid & o_wr_ready;
  assign w_rd_fire  = i_rd_valid & o_rd_ready;

  assign o_sram_we    = w_wr_fire;
  assign o_sram_re    = w_rd_fire;
  assign o_sram_ce    = w_wr_fire | w_rd_fire;
  assign o_sram_waddr = i_wr_addr;
  assign o_sram_wdata = i_wr_data;
  assign o_sram_raddr = i_rd_addr;

  assign w_push      = r_pend;
  assign o_rsp_valid = (r_cnt != 2'd0);
  assign w_pop       = o_rsp_valid & i_rsp_ready;
  assign o_rsp_data  = r_mem[r_rptr];

`ifdef SRAM_CTRL_FWD_EN
  logic                  r_fwd_sel;
  logic [DATA_WIDTH-1:0] r_fwd_dat;

  // Capture same-address write data at read fire; it replaces the SRAM's stale word on the push.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fwd_sel <= 1'b0;
      r_fwd_dat <= '0;
    end else begin
      r_fwd_sel <= w_rd_fire & w_wr_fire & (i_rd_addr == i_wr_addr);
      r_fwd_dat <= i_wr_data;
    end
  end

  assign w_push_dat = r_fwd_sel ? r_fwd_dat : i_sram_rdata;
`else
  assign w_push_dat = i_sram_rdata;
`endif

  // Track the single read that is inside the SRAM read register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_rd_fire;
    end
  end

  // Response buffer storage and pointers; reset discards everything buffered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 3; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= 2'd0;
      r_rptr <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_push_dat;
        r_wptr        <= (r_wptr == 2'd2) ? 2'd0 : r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == 2'd2) ? 2'd0 : r_rptr + 2'd1;
      end
    end
  end

  // Entry count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
